// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults and saturation bounds for the pe_dbuf processing element.
//   DATA_W_DEF / RES_W_DEF : default operand and partial-sum widths
//   sat_max / sat_min      : largest / smallest signed value representable in res_w bits
package pe_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RES_W_DEF  = 20;

    function automatic longint sat_max(input int unsigned res_w);
        return (longint'(1) << (res_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned res_w);
        return -(longint'(1) << (res_w - 1));
    endfunction

endpackage

// File: rtl/pe_mac.sv
// pe_mac: combinational signed multiply-add with optional saturation.
//   a    in  DATA_W : signed data operand
//   w    in  DATA_W : signed weight operand
//   psum in  RES_W  : signed incoming partial sum
//   sum  out RES_W  : a*w + psum, clamped (SAT_EN=1) or wrapped (SAT_EN=0)
//   sat  out 1      : high when the result was clamped
module pe_mac
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RES_W  = RES_W_DEF,
    parameter int unsigned SAT_EN = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    input  logic [RES_W-1:0]  psum,
    output logic [RES_W-1:0]  sum,
    output logic              sat
);

    localparam int unsigned PW = 2 * DATA_W;

    // One guard bit: the product fits in RES_W bits, so the sum never overflows RES_W+1.
    localparam logic signed [RES_W:0] SatHi = (RES_W + 1)'(sat_max(RES_W));
    localparam logic signed [RES_W:0] SatLo = (RES_W + 1)'(sat_min(RES_W));

    logic signed [PW-1:0] w_prod;
    logic signed [RES_W:0] w_prod_ext;
    logic signed [RES_W:0] w_psum_ext;
    logic signed [RES_W:0] w_sum;

    assign w_prod     = $signed(a) * $signed(w);
    assign w_prod_ext = {{(RES_W + 1 - PW){w_prod[PW-1]}}, w_prod};
    assign w_psum_ext = {psum[RES_W-1], psum};
    assign w_sum      = w_prod_ext + w_psum_ext;

    always_comb begin
        sum = w_sum[RES_W-1:0];
        sat = 1'b0;
        if (SAT_EN != 0) begin
            if (w_sum > SatHi) begin
                sum = SatHi[RES_W-1:0];
                sat = 1'b1;
            end else if (w_sum < SatLo) begin
                sum = SatLo[RES_W-1:0];
                sat = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_dbuf.sv
// pe_dbuf: systolic processing element with double-buffered (shadow/active) weight.
//   clk, rst (sync, active-low)
//   in_valid, in_conf, in_swap, clr_sat : beat qualifiers and control
//   in_north (DATA_W) : data on compute beats, weight on load beats
//   in_west  (RES_W)  : incoming partial sum
//   out_south, out_east, out_valid, out_conf, out_swap : registered daisy-chain outputs
//   sat_flag : sticky saturation indicator
module pe_dbuf
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RES_W  = RES_W_DEF,
    parameter int unsigned SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_conf,
    input  logic              in_swap,
    input  logic              clr_sat,
    input  logic [DATA_W-1:0] in_north,
    input  logic [RES_W-1:0]  in_west,
    output logic [DATA_W-1:0] out_south,
    output logic [RES_W-1:0]  out_east,
    output logic              out_valid,
    output logic              out_conf,
    output logic              out_swap,
    output logic              sat_flag
);

    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_active;
    logic [DATA_W-1:0] r_south;
    logic [RES_W-1:0]  r_east;
    logic              r_valid;
    logic              r_conf;
    logic              r_swap;
    logic              r_sat;

    logic [RES_W-1:0]  w_sum;
    logic              w_sat;
    logic              w_load;
    logic              w_comp;

    assign w_load = in_valid & in_conf;
    assign w_comp = in_valid & ~in_conf;

    pe_mac #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W),
        .SAT_EN (SAT_EN)
    ) u_mac (
        .a    (in_north),
        .w    (r_active),
        .psum (in_west),
        .sum  (w_sum),
        .sat  (w_sat)
    );

    // Non-blocking reads of r_shadow/r_active give the "old value" semantics needed
    // when a swap coincides with a load or compute beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_south  <= '0;
            r_east   <= '0;
            r_valid  <= 1'b0;
            r_conf   <= 1'b0;
            r_swap   <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            r_conf  <= w_load;
            r_swap  <= in_swap;
            if (in_swap) begin
                r_active <= r_shadow;
            end
            if (w_load) begin
                r_shadow <= in_north;
                r_south  <= r_shadow;
            end else if (w_comp) begin
                r_south <= in_north;
                r_east  <= w_sum;
            end
            // A new saturation wins over a coincident clear.
            if (w_comp && w_sat) begin
                r_sat <= 1'b1;
            end else if (clr_sat) begin
                r_sat <= 1'b0;
            end
        end
    end

    assign out_south = r_south;
    assign out_east  = r_east;
    assign out_valid = r_valid;
    assign out_conf  = r_conf;
    assign out_swap  = r_swap;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_pe_dbuf.sv
module tb_pe_dbuf;

    localparam int DW   = 8;
    localparam int RW   = 20;
    localparam int MAXV = (1 << (RW - 1)) - 1;
    localparam int MINV = -(1 << (RW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_conf, in_swap, clr_sat;
    logic [DW-1:0] in_north;
    logic [RW-1:0] in_west;
    logic [DW-1:0] out_south;
    logic [RW-1:0] out_east;
    logic          out_valid, out_conf, out_swap, sat_flag;

    int total = 0;
    int bad   = 0;

    // Reference state, plain integers.
    int m_shadow, m_active, m_south, m_east, m_valid, m_conf, m_swap, m_sat;

    pe_dbuf #(
        .DATA_W (DW),
        .RES_W  (RW),
        .SAT_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_conf   (in_conf),
        .in_swap   (in_swap),
        .clr_sat   (clr_sat),
        .in_north  (in_north),
        .in_west   (in_west),
        .out_south (out_south),
        .out_east  (out_east),
        .out_valid (out_valid),
        .out_conf  (out_conf),
        .out_swap  (out_swap),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit c, input bit s, input bit cl,
                         input int n, input int w);
        int sum;
        int nxt_active;
        if (!r) begin
            m_shadow = 0; m_active = 0; m_south = 0; m_east = 0;
            m_valid = 0; m_conf = 0; m_swap = 0; m_sat = 0;
            return;
        end
        nxt_active = s ? m_shadow : m_active;
        if (v && c) begin
            m_south  = m_shadow;
            m_shadow = n;
            if (cl) m_sat = 0;
        end else if (v) begin
            sum = n * m_active + w;
            m_south = n;
            if (sum > MAXV) begin
                m_east = MAXV; m_sat = 1;
            end else if (sum < MINV) begin
                m_east = MINV; m_sat = 1;
            end else begin
                m_east = sum;
                if (cl) m_sat = 0;
            end
        end else if (cl) begin
            m_sat = 0;
        end
        m_active = nxt_active;
        m_valid  = v;
        m_conf   = v && c;
        m_swap   = s;
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs after the edge.
    task automatic step(input bit r, input bit v, input bit c, input bit s, input bit cl,
                        input int n, input int w);
        rst = r; in_valid = v; in_conf = c; in_swap = s; clr_sat = cl;
        in_north = n[DW-1:0];
        in_west  = w[RW-1:0];
        @(posedge clk);
        #1;
        model(r, v, c, s, cl, n, w);
        check("south", int'($signed(out_south)), m_south);
        check("east",  int'($signed(out_east)),  m_east);
        check("valid", int'(out_valid), m_valid);
        check("conf",  int'(out_conf),  m_conf);
        check("swap",  int'(out_swap),  m_swap);
        check("sat",   int'(sat_flag),  m_sat);
    endtask

    initial begin
        int n, w, sel;
        bit v, c, s, cl, r;
        m_shadow = 0; m_active = 0; m_south = 0; m_east = 0;
        m_valid = 0; m_conf = 0; m_swap = 0; m_sat = 0;

        // Reset with every control input asserted: reset must dominate.
        step(0, 1, 1, 1, 1, 55, 1000);
        step(0, 1, 0, 1, 0, 9, 77);

        // Load 5, swap, compute 3*5+10.
        step(1, 1, 1, 0, 0, 5, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 3, 10);
        check("east_25", int'($signed(out_east)), 25);
        check("south_3", int'($signed(out_south)), 3);

        // Shadow=-2 while active=5; swap with compute uses old weight.
        step(1, 1, 1, 0, 0, -2, 0);
        step(1, 1, 0, 1, 0, 4, 0);
        check("east_20", int'($signed(out_east)), 20);
        step(1, 1, 0, 0, 0, 4, 0);
        check("east_m8", int'($signed(out_east)), -8);

        // Two load beats: shift chain.
        step(1, 1, 1, 0, 0, 7, 0);
        check("conf_1", int'(out_conf), 1);
        step(1, 1, 1, 0, 0, 9, 0);
        check("south_7", int'($signed(out_south)), 7);
        check("conf_2", int'(out_conf), 1);

        // Positive and negative saturation.
        step(1, 1, 1, 0, 0, 127, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 127, 524000);
        check("east_pos_sat", int'($signed(out_east)), 524287);
        check("sat_set", int'(sat_flag), 1);
        step(1, 1, 1, 0, 0, -128, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 127, -520000);
        check("east_neg_sat", int'($signed(out_east)), -524288);

        // Clear with no saturation, then idle hold.
        step(1, 0, 0, 0, 1, 0, 0);
        check("sat_clr", int'(sat_flag), 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, i, i);
        check("idle_east", int'($signed(out_east)), -524288);

        // Reset during a compute beat clears weights too.
        step(0, 1, 0, 0, 0, 100, 100);
        check("rst_east", int'($signed(out_east)), 0);
        step(1, 1, 0, 0, 0, 5, 7);
        check("zero_weight", int'($signed(out_east)), 7);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 5) == 0);
            cl = ($urandom_range(0, 7) == 0);
            n  = int'($urandom_range(0, 255)) - 128;
            sel = int'($urandom_range(0, 3));
            if (sel == 0) w = 524287 - int'($urandom_range(0, 20000));
            else if (sel == 1) w = -524288 + int'($urandom_range(0, 20000));
            else w = int'($urandom_range(0, (1 << RW) - 1)) - (1 << (RW - 1));
            step(r, v, c, s, cl, n, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
